// File: rtl/axi_rd_arbiter_pkg.sv
// Shared definitions for the AXI read arbiter: FSM encoding, fixed AR
// attributes, error flag positions and the 4 KB boundary check.
package axi_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  localparam logic [2:0] AR_SIZE  = 3'd3;    // 8-byte beats
  localparam logic [1:0] AR_BURST = 2'b01;   // INCR
  localparam logic       AR_LOCK  = 1'b0;
  localparam logic [3:0] AR_CACHE = 4'b0011;
  localparam logic [2:0] AR_PROT  = 3'b000;
  localparam logic [3:0] AR_QOS   = 4'b0000;

  localparam int ERR_RID  = 0;
  localparam int ERR_LAST = 1;
  localparam int ERR_4KB  = 2;

  localparam int BEAT_CNT_W = 9;

  // True when an INCR burst of (len+1) 8-byte beats starting at the given
  // page offset runs past the end of its 4 KB page.
  function automatic logic crosses_4kb(input logic [11:0] offs, input logic [7:0] len);
    logic [13:0] end_sum;
    end_sum = {2'b00, offs} + (({6'd0, len} + 14'd1) << 3);
    return end_sum > 14'd4096;
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after rr_ptr,
// wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               any_req
);

  int j;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    j         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any_req && req[j]) begin
        any_req   = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = PTR_W'(j);
      end
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read master among NUM_REQ requesters,
// one burst outstanding at a time, with sticky protocol error flags.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int NUM_REQ            = 3,
  parameter int C_S_AXI_ID_WIDTH   = 3,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 64
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_REQ*C_S_AXI_ADDR_WIDTH-1:0] req_araddr,
  input  logic [NUM_REQ*8-1:0]                  req_arlen,
  input  logic [NUM_REQ-1:0]                    req_arvalid,
  output logic [NUM_REQ-1:0]                    req_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]         req_rdata,
  output logic [1:0]                            req_rresp,
  output logic                                  req_rlast,
  output logic [NUM_REQ-1:0]                    req_rvalid,
  input  logic [NUM_REQ-1:0]                    req_rready,
  output logic [C_S_AXI_ID_WIDTH-1:0]           M_axi_arid,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]         M_axi_araddr,
  output logic [7:0]                            M_axi_arlen,
  output logic                                  M_axi_arvalid,
  input  logic                                  M_axi_arready,
  output logic [2:0]                            M_axi_arsize,
  output logic [1:0]                            M_axi_arburst,
  output logic                                  M_axi_arlock,
  output logic [3:0]                            M_axi_arcache,
  output logic [2:0]                            M_axi_arprot,
  output logic [3:0]                            M_axi_arqos,
  input  logic [C_S_AXI_ID_WIDTH-1:0]           M_axi_rid,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]         M_axi_rdata,
  input  logic [1:0]                            M_axi_rresp,
  input  logic                                  M_axi_rlast,
  input  logic                                  M_axi_rvalid,
  output logic                                  M_axi_rready,
  output logic                                  busy,
  output logic [2:0]                            err_status
);

  localparam int AW    = C_S_AXI_ADDR_WIDTH;
  localparam int IDW   = C_S_AXI_ID_WIDTH;
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e                  state_q, state_d;
  logic [PTR_W-1:0]        grant_q, grant_d;
  logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [AW-1:0]           araddr_q, araddr_d;
  logic [7:0]              arlen_q, arlen_d;
  logic [BEAT_CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [2:0]              err_q, err_d;

  logic [AW-1:0]           addr_arr [NUM_REQ];
  logic [7:0]              len_arr  [NUM_REQ];
  logic [NUM_REQ-1:0]      arb_grant;
  logic [PTR_W-1:0]        arb_idx;
  logic                    arb_any;
  logic [AW-1:0]           sel_addr;
  logic [7:0]              sel_len;

  logic [NUM_REQ-1:0]      arready_c, rvalid_c;
  logic                    arvalid_c, rready_c, r_hs;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi] = req_araddr[gi*AW +: AW];
    assign len_arr[gi]  = req_arlen[gi*8 +: 8];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req       (req_arvalid),
    .rr_ptr    (rr_ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_req   (arb_any)
  );

  assign sel_addr = addr_arr[arb_idx];
  assign sel_len  = len_arr[arb_idx];

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    araddr_d   = araddr_q;
    arlen_d    = arlen_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;
    arready_c  = '0;
    rvalid_c   = '0;
    arvalid_c  = 1'b0;
    rready_c   = 1'b0;
    r_hs       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          arready_c = arb_grant;
          grant_d   = arb_idx;
          araddr_d  = sel_addr;
          arlen_d   = sel_len;
          if (crosses_4kb(sel_addr[11:0], sel_len)) err_d[ERR_4KB] = 1'b1;
          state_d   = ST_ADDR;
        end
      end
      ST_ADDR: begin
        arvalid_c = 1'b1;
        if (M_axi_arready) begin
          beat_cnt_d = '0;
          state_d    = ST_DATA;
        end
      end
      ST_DATA: begin
        rready_c          = req_rready[grant_q];
        rvalid_c[grant_q] = M_axi_rvalid;
        r_hs              = M_axi_rvalid && rready_c;
        if (r_hs) begin
          // beat_cnt_q holds the number of beats already taken, so the
          // final beat of a well-formed burst sees beat_cnt_q == arlen.
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (M_axi_rid != IDW'(grant_q)) err_d[ERR_RID] = 1'b1;
          if (M_axi_rlast) begin
            if (beat_cnt_q != {1'b0, arlen_q}) err_d[ERR_LAST] = 1'b1;
            rr_ptr_d = (grant_q == PTR_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
            state_d  = ST_IDLE;
          end else if (beat_cnt_q == {1'b0, arlen_q}) begin
            err_d[ERR_LAST] = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      araddr_q   <= '0;
      arlen_q    <= '0;
      beat_cnt_q <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      araddr_q   <= araddr_d;
      arlen_q    <= arlen_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
    end
  end

  // Handshake outputs are forced low for the whole time reset is held,
  // not only from the first reset edge onward.
  assign req_arready   = reset ? '0 : arready_c;
  assign req_rvalid    = reset ? '0 : rvalid_c;
  assign M_axi_arvalid = reset ? 1'b0 : arvalid_c;
  assign M_axi_rready  = reset ? 1'b0 : rready_c;

  assign M_axi_arid    = IDW'(grant_q);
  assign M_axi_araddr  = araddr_q;
  assign M_axi_arlen   = arlen_q;
  assign M_axi_arsize  = AR_SIZE;
  assign M_axi_arburst = AR_BURST;
  assign M_axi_arlock  = AR_LOCK;
  assign M_axi_arcache = AR_CACHE;
  assign M_axi_arprot  = AR_PROT;
  assign M_axi_arqos   = AR_QOS;

  assign req_rdata  = M_axi_rdata;
  assign req_rresp  = M_axi_rresp;
  assign req_rlast  = M_axi_rlast;
  assign busy       = (state_q != ST_IDLE);
  assign err_status = err_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed plus randomized bench for axi_rd_arbiter against a behavioural
// model of grant order, beat routing and sticky error flags.
module tb_axi_rd_arbiter;

  localparam int N   = 3;
  localparam int IDW = 3;
  localparam int AW  = 32;
  localparam int DW  = 64;

  logic             clk = 1'b0;
  logic             reset;
  logic [N*AW-1:0]  req_araddr;
  logic [N*8-1:0]   req_arlen;
  logic [N-1:0]     req_arvalid;
  logic [N-1:0]     req_arready;
  logic [DW-1:0]    req_rdata;
  logic [1:0]       req_rresp;
  logic             req_rlast;
  logic [N-1:0]     req_rvalid;
  logic [N-1:0]     req_rready;
  logic [IDW-1:0]   M_axi_arid;
  logic [AW-1:0]    M_axi_araddr;
  logic [7:0]       M_axi_arlen;
  logic             M_axi_arvalid;
  logic             M_axi_arready;
  logic [2:0]       M_axi_arsize;
  logic [1:0]       M_axi_arburst;
  logic             M_axi_arlock;
  logic [3:0]       M_axi_arcache;
  logic [2:0]       M_axi_arprot;
  logic [3:0]       M_axi_arqos;
  logic [IDW-1:0]   M_axi_rid;
  logic [DW-1:0]    M_axi_rdata;
  logic [1:0]       M_axi_rresp;
  logic             M_axi_rlast;
  logic             M_axi_rvalid;
  logic             M_axi_rready;
  logic             busy;
  logic [2:0]       err_status;

  always #5 clk = ~clk;

  axi_rd_arbiter #(
    .NUM_REQ            (N),
    .C_S_AXI_ID_WIDTH   (IDW),
    .C_S_AXI_ADDR_WIDTH (AW),
    .C_S_AXI_DATA_WIDTH (DW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_araddr    (req_araddr),
    .req_arlen     (req_arlen),
    .req_arvalid   (req_arvalid),
    .req_arready   (req_arready),
    .req_rdata     (req_rdata),
    .req_rresp     (req_rresp),
    .req_rlast     (req_rlast),
    .req_rvalid    (req_rvalid),
    .req_rready    (req_rready),
    .M_axi_arid    (M_axi_arid),
    .M_axi_araddr  (M_axi_araddr),
    .M_axi_arlen   (M_axi_arlen),
    .M_axi_arvalid (M_axi_arvalid),
    .M_axi_arready (M_axi_arready),
    .M_axi_arsize  (M_axi_arsize),
    .M_axi_arburst (M_axi_arburst),
    .M_axi_arlock  (M_axi_arlock),
    .M_axi_arcache (M_axi_arcache),
    .M_axi_arprot  (M_axi_arprot),
    .M_axi_arqos   (M_axi_arqos),
    .M_axi_rid     (M_axi_rid),
    .M_axi_rdata   (M_axi_rdata),
    .M_axi_rresp   (M_axi_rresp),
    .M_axi_rlast   (M_axi_rlast),
    .M_axi_rvalid  (M_axi_rvalid),
    .M_axi_rready  (M_axi_rready),
    .busy          (busy),
    .err_status    (err_status)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          m_ptr = 0;
  logic [2:0]  m_err = 3'b000;
  logic [31:0] addr_a [N];
  logic [7:0]  len_a  [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expd);
    n_vec++;
    assert (obs === expd) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expd);
    end
  endtask

  task automatic drive_req();
    for (int i = 0; i < N; i++) begin
      req_araddr[i*AW +: AW] = addr_a[i];
      req_arlen[i*8 +: 8]    = len_a[i];
    end
  endtask

  function automatic int model_grant(input logic [N-1:0] mask);
    for (int k = 0; k < N; k++) begin
      if (mask[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    M_axi_arready = 1'b0;
    M_axi_rvalid  = 1'b0;
    M_axi_rlast   = 1'b0;
    req_rready    = '0;
    req_arvalid   = 3'b101;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_arvalid", M_axi_arvalid, 0);
    chk("rst_rready", M_axi_rready, 0);
    chk("rst_req_arready", req_arready, 0);
    chk("rst_req_rvalid", req_rvalid, 0);
    chk("rst_err", err_status, 0);
    reset       = 1'b0;
    req_arvalid = '0;
    m_ptr = 0;
    m_err = 3'b000;
  endtask

  // mode: 0 = granted requester always ready, 1 = toggles every cycle, 2 = random
  task automatic burst(input logic [N-1:0] mask, input int rid_val, input int last_at_in,
                       input int mode, input bit gaps, input int abort_at);
    int          g, last_at, k, cyc, got, wait_ar;
    logic [31:0] e_addr;
    logic [7:0]  e_len;
    logic [N-1:0] rr;
    logic [IDW-1:0] rid;
    logic [DW-1:0] d;
    logic [1:0]  rs;
    bit          vld, lst, done;

    g       = model_grant(mask);
    e_addr  = addr_a[g];
    e_len   = len_a[g];
    last_at = (last_at_in < 0) ? int'(e_len) : last_at_in;

    @(negedge clk);
    drive_req();
    req_arvalid = mask;
    #1;
    chk("idle_busy", busy, 0);
    chk("grant_arready", req_arready, 64'd1 << g);
    if (int'(e_addr[11:0]) + (int'(e_len) + 1) * 8 > 4096) m_err[2] = 1'b1;

    // Requester inputs change after the grant; the issued AR must not follow.
    wait_ar = $urandom_range(0, 2);
    for (int w = 0; w <= wait_ar; w++) begin
      @(negedge clk);
      if (w == 0) begin
        for (int i = 0; i < N; i++) begin
          addr_a[i] = $urandom;
          len_a[i]  = 8'($urandom);
        end
        drive_req();
      end
      M_axi_arready = (w == wait_ar);
      #1;
      chk("ar_valid", M_axi_arvalid, 1);
      chk("ar_addr", M_axi_araddr, e_addr);
      chk("ar_len", M_axi_arlen, e_len);
      chk("ar_id", M_axi_arid, g);
      chk("ar_busy", busy, 1);
      chk("ar_req_arready", req_arready, 0);
      chk("ar_rready", M_axi_rready, 0);
    end

    k = 0; got = 0; done = 1'b0; cyc = 0;
    while (!done) begin
      @(negedge clk);
      M_axi_arready = 1'b0;
      if (abort_at >= 0 && k == abort_at) begin
        reset        = 1'b1;
        M_axi_rvalid = 1'b0;
        M_axi_rlast  = 1'b0;
        @(negedge clk);
        req_arvalid = 3'b111;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_arvalid", M_axi_arvalid, 0);
        chk("abort_rready", M_axi_rready, 0);
        chk("abort_req_rvalid", req_rvalid, 0);
        chk("abort_req_arready", req_arready, 0);
        chk("abort_err", err_status, 0);
        reset       = 1'b0;
        req_arvalid = '0;
        m_ptr = 0;
        m_err = 3'b000;
        $display("burst grant=%0d aborted after %0d beats", g, k);
        return;
      end
      cyc++;
      if (cyc > 2000) begin
        chk("data_timeout", k, last_at + 1);
        break;
      end
      vld = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      rr  = N'($urandom);
      case (mode)
        0:       rr[g] = 1'b1;
        1:       rr[g] = cyc[0];
        default: rr[g] = 1'($urandom);
      endcase
      lst = vld && (k == last_at);
      d   = {$urandom, $urandom};
      rs  = 2'($urandom);
      rid = (rid_val < 0) ? IDW'(g) : IDW'(rid_val);
      M_axi_rvalid = vld;
      M_axi_rlast  = lst;
      M_axi_rdata  = d;
      M_axi_rresp  = rs;
      M_axi_rid    = rid;
      req_rready   = rr;
      #1;
      chk("r_rready_mirror", M_axi_rready, rr[g]);
      chk("r_rvalid_route", req_rvalid, vld ? (64'd1 << g) : 64'd0);
      chk("r_arvalid_low", M_axi_arvalid, 0);
      chk("r_req_arready", req_arready, 0);
      if (vld) begin
        chk("r_data", req_rdata, d);
        chk("r_resp", req_rresp, rs);
        chk("r_last", req_rlast, lst);
      end
      if (vld && rr[g]) begin
        if (int'(rid) != g) m_err[0] = 1'b1;
        if (lst ? (k != int'(e_len)) : (k == int'(e_len))) m_err[1] = 1'b1;
        if (req_rvalid[g] && req_rready[g]) got++;
        k++;
        if (lst) done = 1'b1;
      end
    end

    @(negedge clk);
    M_axi_rvalid = 1'b0;
    M_axi_rlast  = 1'b0;
    req_arvalid  = '0;
    #1;
    chk("end_busy", busy, 0);
    chk("end_beats", got, last_at + 1);
    chk("end_err", err_status, m_err);
    m_ptr = (g + 1) % N;
    $display("burst grant=%0d addr=%h len=%0d beats=%0d err=%b", g, e_addr, e_len, got, err_status);
  endtask

  initial begin
    reset         = 1'b1;
    req_araddr    = '0;
    req_arlen     = '0;
    req_arvalid   = '0;
    req_rready    = '0;
    M_axi_arready = 1'b0;
    M_axi_rid     = '0;
    M_axi_rdata   = '0;
    M_axi_rresp   = '0;
    M_axi_rlast   = 1'b0;
    M_axi_rvalid  = 1'b0;
    for (int i = 0; i < N; i++) begin
      addr_a[i] = '0;
      len_a[i]  = '0;
    end

    apply_reset();
    chk("c_arsize", M_axi_arsize, 3);
    chk("c_arburst", M_axi_arburst, 1);
    chk("c_arlock", M_axi_arlock, 0);
    chk("c_arcache", M_axi_arcache, 4'b0011);
    chk("c_arprot", M_axi_arprot, 0);
    chk("c_arqos", M_axi_arqos, 0);

    // Single 24-beat burst from requester 0
    addr_a[0] = 32'h0000_1000;
    len_a[0]  = 8'h17;
    burst(3'b001, -1, -1, 0, 1'b0, -1);

    // Contention: all three valid, expect 0,1,2,0,1,2
    apply_reset();
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < N; i++) begin
        addr_a[i] = {$urandom_range(0, 32'hFFFFF), 12'h000};
        len_a[i]  = 8'($urandom_range(0, 31));
      end
      burst(3'b111, -1, -1, 0, 1'b0, -1);
    end

    // Backpressure: requester 1 toggles rready, master inserts gaps
    addr_a[1] = 32'h0002_0000;
    len_a[1]  = 8'd23;
    burst(3'b010, -1, -1, 1, 1'b1, -1);

    // Randomized traffic
    for (int b = 0; b < 12; b++) begin
      for (int i = 0; i < N; i++) begin
        addr_a[i] = $urandom & 32'hFFFF_FFF8;
        len_a[i]  = 8'($urandom_range(0, 31));
      end
      burst(3'($urandom_range(1, 7)), -1, -1, $urandom_range(0, 2), 1'($urandom), -1);
    end

    // Error flags, one at a time
    apply_reset();
    addr_a[0] = 32'h0000_3000; len_a[0] = 8'd3;
    burst(3'b001, 2, -1, 0, 1'b0, -1);
    addr_a[1] = 32'h0000_4000; len_a[1] = 8'd7;
    burst(3'b010, -1, 4, 0, 1'b0, -1);
    addr_a[2] = 32'h0000_0FF0; len_a[2] = 8'd3;
    burst(3'b100, -1, -1, 0, 1'b0, -1);

    // Reset in the middle of a data phase, then resume
    addr_a[0] = 32'h0000_5000; len_a[0] = 8'd23;
    burst(3'b001, -1, -1, 0, 1'b0, 10);
    addr_a[2] = 32'h0000_6000; len_a[2] = 8'd5;
    burst(3'b100, -1, -1, 2, 1'b1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 NUM_REQ, default 3, number of read requesters (input-layer fetch, weight fetch, bias fetch); legal range 2..8.
REQ-002 C_S_AXI_ID_WIDTH, default 3, ARID/RID width; SHALL satisfy 2**C_S_AXI_ID_WIDTH >= NUM_REQ.
REQ-003 C_S_AXI_ADDR_WIDTH, default 32, address width.
REQ-004 C_S_AXI_DATA_WIDTH, default 64, read data width.
REQ-005 clk  in  1  single clock for all logic.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 req_araddr  in  NUM_REQ*ADDR  packed per-requester burst start address; requester i occupies slice i.
REQ-008 req_arlen  in  NUM_REQ*8  packed per-requester AXI burst length (beats-1).
REQ-009 req_arvalid  in  NUM_REQ  per-requester request valid.
REQ-010 req_arready  out  NUM_REQ  per-requester request accepted, one-hot pulse.
REQ-011 req_rdata  out  DATA  read data, broadcast to all requesters.
REQ-012 req_rresp  out  2  read response, broadcast.
REQ-013 req_rlast  out  1  last beat, broadcast.
REQ-014 req_rvalid  out  NUM_REQ  one-hot beat valid, routed to the granted requester only.
REQ-015 req_rready  in  NUM_REQ  per-requester beat ready.
REQ-016 M_axi_arid/araddr/arlen/arvalid  out  ID/ADDR/8/1  master AR channel; M_axi_arready  in  1.
REQ-017 M_axi_arsize/arburst/arlock/arcache/arprot/arqos  out  3/2/1/4/3/4  constants 3, 1 (INCR), 0, 4'b0011, 0, 0.
REQ-018 M_axi_rid/rdata/rresp/rlast/rvalid  in  ID/DATA/2/1/1; M_axi_rready  out  1.
REQ-019 busy  out  1  high whenever the FSM is not IDLE.
REQ-020 err_status  out  3  sticky flags: bit0 RID mismatch, bit1 RLAST/beat-count mismatch, bit2 4 KB boundary crossing.

Function
REQ-021 FSM states SHALL be IDLE, ADDR, DATA; at most one burst is outstanding.
REQ-022 IDLE: if any req_arvalid is high, grant the first requester at or after rr_ptr (wrapping modulo NUM_REQ), latch its araddr/arlen, and go to ADDR.
REQ-023 On grant, req_arready[grant] SHALL pulse high for exactly that cycle; a requester is acknowledged once per burst.
REQ-024 ADDR: M_axi_arvalid high with latched address, latched arlen, and arid = grant index; fields stay stable until M_axi_arready; on handshake go to DATA.
REQ-025 Latency: req_arvalid high in cycle N with FSM in IDLE -> M_axi_arvalid high in cycle N+1.
REQ-026 DATA: M_axi_rready = req_rready[grant] (combinational); req_rvalid[grant] = M_axi_rvalid; all other req_rvalid bits are 0; data/resp/last pass through combinationally.
REQ-027 A beat counter (9 bits) increments on every R handshake; on an RLAST handshake go to IDLE and set rr_ptr = (grant+1) mod NUM_REQ.
REQ-028 When a handshake beat has M_axi_rid != grant, err_status[0] SHALL set.
REQ-029 When RLAST arrives with count != arlen, or count reaches arlen+1 without RLAST, err_status[1] SHALL set; the FSM still leaves DATA only on RLAST.
REQ-030 At grant, if araddr[11:0] + (arlen+1)*8 > 4096, err_status[2] SHALL set; the burst is still issued unchanged.
REQ-031 A req_arvalid drop before the grant SHALL cancel the request; after the grant, arvalid is ignored until the next IDLE.
REQ-032 M_axi_rready SHALL be 0 outside DATA.

Reset
REQ-033 While reset is high: FSM=IDLE, rr_ptr=0, beat counter=0, err_status=0, and all valid/ready outputs = 0; an in-flight burst is abandoned; data outputs are don't-care.

Structure
REQ-034 The shared package SHALL hold the state encoding (IDLE=2'd0, ADDR=2'd1, DATA=2'd2), the fixed AR constants, and the error-bit indices.
REQ-035 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req vector and rr_ptr, output one-hot grant and index), purely combinational.

Verification
REQ-036 Single request: req0 araddr=0x1000, arlen=0x17 -> one AR with arid=0, 24 beats routed to req0 only, busy falls the cycle after RLAST, err_status=0.
REQ-037 Contention: all 3 requesters continuously valid -> grant order 0,1,2,0,1,2 across 6 bursts.
REQ-038 Backpressure: req1 toggles rready every cycle -> M_axi_rready mirrors it, no beat lost or duplicated, 24-beat count exact.
REQ-039 Errors: RID=2 while grant=0 -> err_status[0]=1; RLAST on beat 5 of arlen=7 -> err_status[1]=1; araddr=0x0FF0 with arlen=3 -> err_status[2]=1.
REQ-040 Reset mid-DATA: assert reset at beat 10 -> next cycle all valid/ready outputs=0, FSM=IDLE, err_status=0; a new request then proceeds normally.
